// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge stage.
// Holds the FSM encoding, kernel weights and magnitude saturation.
package sobel_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Sobel kernel: side taps weigh 1, middle taps 2, the centre 0
  localparam int K_SIDE = 1;
  localparam int K_MID  = 2;
  localparam int K_CTR  = 0;

  function automatic logic [31:0] sat_mag(input logic signed [31:0] gx,
                                          input logic signed [31:0] gy,
                                          input int dwidth);
    logic [31:0] ax;
    logic [31:0] ay;
    logic [31:0] m;
    logic [31:0] lim;
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    m   = (ax + ay) >> 1;
    lim = (32'd1 << dwidth) - 32'd1;
    return (m > lim) ? lim : m;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sobel_stream_filter_window.sv
// Line buffer for the 3x3 neighbourhood; the incoming pixel acts as the
// newest tap, so the taps already show the window after the next shift.
module sobel_window #(
  parameter int IMG_WIDTH = 720,
  parameter int DWIDTH    = 8
) (
  input  logic              clk,
  input  logic              shift_en,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] p00,
  output logic [DWIDTH-1:0] p01,
  output logic [DWIDTH-1:0] p02,
  output logic [DWIDTH-1:0] p10,
  output logic [DWIDTH-1:0] p11,
  output logic [DWIDTH-1:0] p12,
  output logic [DWIDTH-1:0] p20,
  output logic [DWIDTH-1:0] p21,
  output logic [DWIDTH-1:0] p22
);

  localparam int DEPTH = 2 * IMG_WIDTH + 2;

  // Together with din these registers span 2*IMG_WIDTH+3 pixels
  logic [DWIDTH-1:0] line [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      line[0] <= din;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign p22 = din;
  assign p21 = line[0];
  assign p20 = line[1];
  assign p12 = line[IMG_WIDTH-1];
  assign p11 = line[IMG_WIDTH];
  assign p10 = line[IMG_WIDTH+1];
  assign p02 = line[2*IMG_WIDTH-1];
  assign p01 = line[2*IMG_WIDTH];
  assign p00 = line[2*IMG_WIDTH+1];

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming Sobel edge stage between the grayscale FIFO and the sobel FIFO:
// fill, run with one write per consumed pixel, then flush the last-row border.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8,
  parameter int CWIDTH     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full,
  output logic              out_wr_en,
  input  logic              thresh_en,
  input  logic [DWIDTH-1:0] threshold,
  output logic              frame_done
);

  localparam int GW = DWIDTH + 4;
  localparam logic [DWIDTH-1:0]    PIX_MAX = '1;
  localparam logic signed [GW-1:0] W_SIDE  = GW'(K_SIDE);
  localparam logic signed [GW-1:0] W_MID   = GW'(K_MID);
  localparam logic signed [GW-1:0] W_CTR   = GW'(K_CTR);

  state_t state, state_nxt;
  logic [CWIDTH-1:0] row, row_nxt, col, col_nxt, aux, aux_nxt;
  logic consume, produce, last;
  logic [DWIDTH-1:0] prod_val, pix_val, mag;
  logic [DWIDTH-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic signed [GW-1:0] gx, gy;
  logic border;
  logic vld_p1, done_p1;

  function automatic logic signed [GW-1:0] sx(input logic [DWIDTH-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  assign in_rd_en = !reset && !in_empty && !out_full && (state != S_FLUSH);
  assign consume  = in_rd_en;

  sobel_window #(.IMG_WIDTH(IMG_WIDTH), .DWIDTH(DWIDTH)) u_window (
    .clk(clock), .shift_en(consume), .din(in_dout),
    .p00(p00), .p01(p01), .p02(p02),
    .p10(p10), .p11(p11), .p12(p12),
    .p20(p20), .p21(p21), .p22(p22)
  );

  // Stage p0: gradients, magnitude, threshold and border of the centre pixel
  assign gx = (sx(p02) * W_SIDE + sx(p12) * W_MID + sx(p22) * W_SIDE + sx(p11) * W_CTR)
            - (sx(p00) * W_SIDE + sx(p10) * W_MID + sx(p20) * W_SIDE);
  assign gy = (sx(p20) * W_SIDE + sx(p21) * W_MID + sx(p22) * W_SIDE)
            - (sx(p00) * W_SIDE + sx(p01) * W_MID + sx(p02) * W_SIDE);
  assign mag = DWIDTH'(sat_mag(32'(gx), 32'(gy), DWIDTH));

  assign border = (row == '0) || (row == CWIDTH'(IMG_HEIGHT - 1)) ||
                  (col == '0) || (col == CWIDTH'(IMG_WIDTH - 1));

  always_comb begin
    pix_val = mag;
    if (thresh_en) pix_val = (mag >= threshold) ? PIX_MAX : '0;
    if (border)    pix_val = '0;
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    aux_nxt   = aux;
    produce   = 1'b0;
    prod_val  = '0;
    last      = 1'b0;
    case (state)
      S_FILL: begin
        if (consume) begin
          if (aux == CWIDTH'(IMG_WIDTH)) begin
            aux_nxt   = '0;
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = S_RUN;
          end else begin
            aux_nxt = aux + CWIDTH'(1);
          end
        end
      end
      S_RUN: begin
        if (consume) begin
          produce  = 1'b1;
          prod_val = pix_val;
          if (col == CWIDTH'(IMG_WIDTH - 1)) begin
            col_nxt = '0;
            row_nxt = (row == CWIDTH'(IMG_HEIGHT - 1)) ? '0 : row + CWIDTH'(1);
          end else begin
            col_nxt = col + CWIDTH'(1);
          end
          // the newest pixel is the frame's last once the centre reaches (H-2, W-2)
          if (row == CWIDTH'(IMG_HEIGHT - 2) && col == CWIDTH'(IMG_WIDTH - 2)) begin
            aux_nxt   = '0;
            state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!out_full) begin
          produce = 1'b1;
          if (aux == CWIDTH'(IMG_WIDTH)) begin
            last      = 1'b1;
            aux_nxt   = '0;
            state_nxt = S_FILL;
          end else begin
            aux_nxt = aux + CWIDTH'(1);
          end
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Stage p1: registered write; a pending write holds while the sink is full
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_FILL;
      row     <= '0;
      col     <= '0;
      aux     <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      out_din <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      aux   <= aux_nxt;
      if (!out_full) begin
        vld_p1  <= produce;
        done_p1 <= last;
        if (produce) out_din <= prod_val;
      end
    end
  end

  assign out_wr_en  = vld_p1 && !out_full;
  assign frame_done = done_p1 && !out_full;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter on a 4x4 image: directed column patterns,
// back-pressure, mid-frame reset and randomised frames against a reference model.
module tb_sobel_stream_filter;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_dout;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] out_din;
  logic       out_full;
  logic       out_wr_en;
  logic       thresh_en;
  logic [7:0] threshold;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  int pix_q[$];
  int out_q[$];
  int fd_idx[$];

  typedef struct packed {
    logic [7:0] c0, c1, c2, c3;
    logic       ten;
    logic [7:0] thr;
    logic [7:0] exp_int;
  } vec_t;

  vec_t tab[5];

  sobel_stream_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(8), .CWIDTH(16)) dut (
    .clock(clk), .reset(rst),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
    .thresh_en(thresh_en), .threshold(threshold), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int col_val(input vec_t v, input int c);
    case (c)
      0: return int'(v.c0);
      1: return int'(v.c1);
      2: return int'(v.c2);
      default: return int'(v.c3);
    endcase
  endfunction

  task automatic load_frame(input vec_t v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix_q.push_back(col_val(v, c));
  endtask

  // Reference: Sobel of the pixel at (r,c) of the frame starting at base
  function automatic int ref_out(input int base, input int r, input int c,
                                 input bit ten, input int thr);
    int gx, gy, m, w, p;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = 0;
    gy = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w  = (dr == 0 || dc == 0) ? 2 : 1;
        p  = pix_q[base + (r + dr) * W + (c + dc)];
        gx += dc * w * p;
        gy += dr * w * p;
      end
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) / 2;
    if (m > 255) m = 255;
    if (ten) m = (m >= thr) ? 255 : 0;
    return m;
  endfunction

  // Called just after a rising edge; plays the source and sink FIFOs
  task automatic run_stream(input string tag, input int n_out, input int feed_limit,
                            input int p_empty, input int p_full,
                            input int full_at, input int full_len);
    int  cyc, feed_idx, fcnt;
    bit  forcing, rd;
    cyc = 0; feed_idx = 0; fcnt = 0;
    out_q.delete();
    fd_idx.delete();
    while (out_q.size() < n_out && feed_idx < feed_limit && cyc < 3000) begin
      forcing  = (full_at >= 0) && (out_q.size() == full_at) && (fcnt < full_len);
      out_full = forcing ? 1'b1 : ($urandom_range(99) < p_full);
      in_empty = (feed_idx >= pix_q.size()) || ($urandom_range(99) < p_empty);
      in_dout  = (feed_idx < pix_q.size()) ? 8'(pix_q[feed_idx]) : 8'd0;
      @(negedge clk);
      if (forcing) begin
        fcnt++;
        chk($sformatf("%s stall in_rd_en c%0d", tag, fcnt), int'(in_rd_en), 0);
        chk($sformatf("%s stall out_wr_en c%0d", tag, fcnt), int'(out_wr_en), 0);
      end
      if (out_wr_en) begin
        out_q.push_back(int'(out_din));
        if (frame_done) fd_idx.push_back(out_q.size());
      end else if (frame_done) begin
        fd_idx.push_back(-1);
      end
      rd = in_rd_en;
      @(posedge clk);
      if (rd) feed_idx++;
      #1;
      cyc++;
    end
    if (cyc >= 3000) chk({tag, " cycle budget"}, cyc, -1);
    // idle tail: nothing further may be written
    in_empty = 1'b1;
    out_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_wr_en) out_q.push_back(int'(out_din));
      if (frame_done) fd_idx.push_back(-2);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frames(input string tag, input int nf, input int tidx);
    int f, k, r, c, e;
    chk({tag, " write count"}, out_q.size(), nf * NPIX);
    chk({tag, " frame_done count"}, fd_idx.size(), nf);
    foreach (fd_idx[i]) chk($sformatf("%s frame_done pos %0d", tag, i), fd_idx[i], (i + 1) * NPIX);
    for (int i = 0; i < nf * NPIX && i < out_q.size(); i++) begin
      f = i / NPIX; k = i % NPIX; r = k / W; c = k % W;
      if (tidx >= 0)
        e = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 0 : int'(tab[tidx].exp_int);
      else
        e = ref_out(f * NPIX, r, c, thresh_en, int'(threshold));
      chk($sformatf("%s f%0d (%0d,%0d)", tag, f, r, c), out_q[i], e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, " in_rd_en"}, int'(in_rd_en), 0);
    chk({tag, " out_wr_en"}, int'(out_wr_en), 0);
    chk({tag, " out_din"}, int'(out_din), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    tab[0] = '{c0: 8'd100, c1: 8'd100, c2: 8'd100, c3: 8'd100, ten: 1'b0, thr: 8'd0,  exp_int: 8'd0};
    tab[1] = '{c0: 8'd0,   c1: 8'd0,   c2: 8'd200, c3: 8'd200, ten: 1'b0, thr: 8'd0,  exp_int: 8'd255};
    tab[2] = '{c0: 8'd0,   c1: 8'd10,  c2: 8'd20,  c3: 8'd30,  ten: 1'b0, thr: 8'd0,  exp_int: 8'd40};
    tab[3] = '{c0: 8'd0,   c1: 8'd10,  c2: 8'd20,  c3: 8'd30,  ten: 1'b1, thr: 8'd50, exp_int: 8'd0};
    tab[4] = '{c0: 8'd0,   c1: 8'd10,  c2: 8'd20,  c3: 8'd30,  ten: 1'b1, thr: 8'd40, exp_int: 8'd255};

    rst = 1'b1; in_empty = 1'b0; out_full = 1'b0; in_dout = 8'd50;
    thresh_en = 1'b0; threshold = 8'd0;
    @(posedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // single frames from the vector table
    for (int t = 0; t < 5; t++) begin
      pix_q.delete();
      load_frame(tab[t]);
      thresh_en = tab[t].ten;
      threshold = tab[t].thr;
      run_stream($sformatf("vec%0d", t), NPIX, 1 << 30, 0, 0, -1, 0);
      check_frames($sformatf("vec%0d", t), 1, t);
    end

    // sink stalls for 10 cycles after the fifth write
    pix_q.delete();
    load_frame(tab[1]);
    thresh_en = 1'b0;
    threshold = 8'd0;
    run_stream("stall", NPIX, 1 << 30, 0, 0, 5, 10);
    check_frames("stall", 1, 1);

    // reset after 7 pixels consumed, then a clean frame
    run_stream("pre_rst", NPIX, 7, 0, 0, -1, 0);
    rst = 1'b1; in_empty = 1'b0; out_full = 1'b0;
    chk_reset_outputs("midrst a");
    @(posedge clk);
    chk_reset_outputs("midrst b");
    @(posedge clk);
    #1 rst = 1'b0;
    run_stream("post_rst", NPIX, 1 << 30, 0, 0, -1, 0);
    check_frames("post_rst", 1, 1);

    // two frames back-to-back with a bursty source
    pix_q.delete();
    load_frame(tab[2]);
    load_frame(tab[2]);
    run_stream("b2b", 2 * NPIX, 1 << 30, 40, 0, -1, 0);
    check_frames("b2b", 2, 2);

    // random frames against the reference model
    for (int run = 0; run < 3; run++) begin
      pix_q.delete();
      for (int i = 0; i < 3 * NPIX; i++) pix_q.push_back($urandom_range(255));
      thresh_en = 1'($urandom_range(1));
      threshold = 8'($urandom_range(255));
      run_stream($sformatf("rand%0d", run), 3 * NPIX, 1 << 30, 30, 20, -1, 0);
      check_frames($sformatf("rand%0d", run), 3, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
